// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: PC width, instruction width, instruction memory
// address size and fetch queue depth.
package fetch_unit_pkg;

    localparam int PC_ADDR_WIDTH    = 16;
    localparam int INST_WIDTH       = 32;
    localparam int INST_ADDR_SIZE   = 6;
    localparam int FETCH_FIFO_DEPTH = 4;
    localparam int PC_STEP          = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO that holds {instr, pc} pairs between the instruction memory
// and decode. The pointers carry one extra MSB so that full and empty can be told apart.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DATA_W = INST_WIDTH + PC_ADDR_WIDTH,
    parameter int DEPTH  = FETCH_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [DATA_W-1:0]        i_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [DATA_W-1:0]        o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;

    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. It owns the PC, issues single-cycle-latency reads,
// queues the returned words with their PCs, and flushes on redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH   = PC_ADDR_WIDTH,
    parameter int IR_WIDTH   = INST_WIDTH,
    parameter int IMEM_AW    = INST_ADDR_SIZE,
    parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lock,
    output logic                imem_req,
    output logic [IMEM_AW-1:0]  imem_addr,
    input  logic [IR_WIDTH-1:0] imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                ir_valid,
    output logic [IR_WIDTH-1:0] ir_data,
    output logic [PC_WIDTH-1:0] ir_pc,
    input  logic                ir_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = IR_WIDTH + PC_WIDTH;

    logic                r_active;
    logic                r_inflight;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_inflight_pc;
    logic [IR_WIDTH-1:0] r_ir_data;
    logic [PC_WIDTH-1:0] r_ir_pc;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [CW-1:0]       w_count;
    logic [CW-1:0]       w_credit;
    logic [PC_WIDTH-1:0] w_issue_pc;
    logic [DW-1:0]       w_head;

    // A redirect takes the issue slot as if the queue and the memory port were already empty.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_credit   = '0;
        w_issue_pc = r_pc;
        if (redirect_valid) begin
            w_issue_pc = redirect_pc & ~PC_WIDTH'(3);
        end else begin
            w_credit = w_count + CW'(r_inflight);
        end
    end

    // r_active holds requests off until the first edge after reset release.
    assign imem_req  = r_active && lock && (w_credit < CW'(FIFO_DEPTH));
    assign imem_addr = w_issue_pc[IMEM_AW+1:2];

    assign w_push   = r_inflight && !redirect_valid;
    assign ir_valid = !w_empty && !redirect_valid;
    assign w_pop    = ir_valid && ir_ready;

    assign ir_data = w_empty ? r_ir_data : w_head[DW-1:PC_WIDTH];
    assign ir_pc   = w_empty ? r_ir_pc   : w_head[PC_WIDTH-1:0];

    fetch_fifo #(
        .DATA_W (DW),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  ({imem_rdata, r_inflight_pc}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active      <= 1'b0;
            r_inflight    <= 1'b0;
            r_pc          <= '0;
            r_inflight_pc <= '0;
            r_ir_data     <= '0;
            r_ir_pc       <= '0;
        end else begin
            r_active   <= 1'b1;
            r_inflight <= imem_req;
            if (imem_req) begin
                r_pc          <= w_issue_pc + PC_WIDTH'(PC_STEP);
                r_inflight_pc <= w_issue_pc;
            end else begin
                r_pc <= w_issue_pc;
            end
            // When the queue is empty, the outputs keep showing the last head.
            if (!w_empty) begin
                r_ir_data <= w_head[DW-1:PC_WIDTH];
                r_ir_pc   <= w_head[PC_WIDTH-1:0];
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));

endmodule
